cpu_seq_m: RTL
==============

Name: cpu_seq_m

Overview:
Single-clock, parametrised successor to the VeriRISC multicycle CPU. An internal state sequencer replaces the external clk2/fetch phase clocks. The core talks to an external memory over a req/ack handshake that tolerates wait states. A run input resumes execution after HLT, and retired instructions are counted. Instruction format is unchanged: opcode in the top 3 bits of the instruction word, operand address in the low AW bits.

Parameters:
DW, 8, data/instruction width; must satisfy DW >= AW+3 (elaboration assertion).
AW, 5, address width; PC and operand address width.
CW, 16, retired-instruction counter width.

Ports:
clk  input  1  system clock, all state on rising edge.
rst_  input  1  asynchronous active-low reset.
run  input  1  resume request, sampled only in S_HALT.
mem_req  output  1  memory access request.
mem_we  output  1  1 = write, 0 = read; valid while mem_req.
mem_addr  output  AW  access address; valid while mem_req.
mem_wdata  output  DW  write data (accumulator); valid while mem_req & mem_we.
mem_rdata  input  DW  read data; sampled on the cycle mem_ack=1.
mem_ack  input  1  access complete; may be high in the same cycle req rises (zero-wait).
halt  output  1  high in S_HALT.
zero  output  1  accum == 0 (combinational).
pc  output  AW  program counter (debug).
accum  output  DW  accumulator (debug).
instr_cnt  output  CW  retired-instruction count.

Behaviour:
- Opcodes are ir[DW-1:DW-3]: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. Operand address ir_addr = ir[AW-1:0].
- Reset (async, rst_ low) sets state=S_START, pc=0, accum=0, ir=0, instr_cnt=0. Outputs during reset: mem_req=0, halt=0.
- Reset mid-access aborts the access: mem_req drops asynchronously and no write completes inside the core.
- mem_req, mem_we, mem_addr and mem_wdata are decoded from state only and stay stable until ack. mem_ack outside mem_req is ignored.
- S_START: one cycle, then S_FETCH.
- S_FETCH: req=1, we=0, addr=pc. On ack: ir<=mem_rdata, pc<=pc+1 (mod 2^AW), go to S_DECODE.
- S_DECODE, with no memory access:
  - HLT: go to S_HALT.
  - SKZ: if accum==0 then pc<=pc+1; go to S_FETCH.
  - JMP: pc<=ir_addr; go to S_FETCH.
  - ADD/AND/XOR/LDA: go to S_READ.
  - STO: go to S_WRITE.
- S_READ: req=1, we=0, addr=ir_addr. On ack, accum gets accum+rdata (mod 2^DW, carry discarded), accum&rdata, accum^rdata, or rdata respectively; then go to S_FETCH.
- S_WRITE: req=1, we=1, addr=ir_addr, wdata=accum. On ack go to S_FETCH.
- S_HALT: halt=1, no requests. run=1 goes to S_FETCH at the current pc, which is already HLT address+1.
- instr_cnt increments by 1 (wrapping) on each instruction completion:
  - HLT/SKZ/JMP: on leaving S_DECODE.
  - ALU/LDA: on S_READ ack.
  - STO: on S_WRITE ack.
- Zero-wait latency: HLT/SKZ/JMP take 2 cycles; ADD/AND/XOR/LDA/STO take 3 cycles. Each wait cycle adds 1.
- PC wrap: fetch at 2^AW-1 sets pc=0. SKZ at pc wrap also wraps.
- zero tracks accum the cycle after any update.

Test Plan:
1. DW=8, AW=5, zero-wait memory. mem[0..3]=0xAA (LDA 10), 0x4B (ADD 11), 0xCC (STO 12), 0x00 (HLT); mem[10]=0x05, mem[11]=0x03 → mem[12]=0x08, accum=0x08, halt=1 after the 12th rising edge following rst_ release, pc=4, instr_cnt=4.
2. accum=0. mem[0]=0x20 (SKZ), mem[1]=0xE5 (JMP 5), mem[2]=0xE7 (JMP 7) → pc reaches 7 with no fetch from address 1. Repeat with accum≠0 → the fetch at 1 occurs and pc=5.
3. Random 0–4 cycle ack delay on a run of ADD/AND/XOR with 0xFF+0x01 → mem_addr, mem_we and mem_wdata stay stable while req is high without ack. Results match a reference model; ADD wraps to 0x00 and zero=1.
4. Halt, then hold run=0 for 20 cycles → no mem_req and counters frozen. Pulse run for 1 cycle → fetch at HLT address+1 on the next cycle.
5. Assert rst_ low during S_WRITE before ack → mem_req falls immediately. After release, pc=0, accum=0, instr_cnt=0, and the first request is a read of address 0.
6. mem[31]=0x00 at pc=31 (AW=5) → after fetch pc=0, then halt. Separately, with CW=4, 17 retirements → instr_cnt=1.

Source files
------------

// File: rtl/cpu_seq_m.sv
// ---------------------------------------------------------------------------
// cpu_seq_m : single-clock multicycle accumulator CPU (VeriRISC successor)
//
// An internal sequencer walks START -> FETCH -> DECODE -> (READ | WRITE |
// HALT) -> FETCH ... and drives one external memory port.
//
// Memory handshake: mem_req is the "valid" of a request; mem_we, mem_addr
// and mem_wdata are qualified by mem_req and hold steady until the cycle in
// which mem_ack is high, which is the single completing cycle ("ready").
// mem_ack may already be high in the first cycle of mem_req (zero wait), and
// any mem_ack seen while mem_req is low is ignored. mem_rdata is captured in
// the acknowledging cycle.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst_       asynchronous active-low reset
//   run        resume request, only looked at while halted
//   mem_req    memory access request
//   mem_we     1 = write, 0 = read (valid while mem_req)
//   mem_addr   access address (valid while mem_req)
//   mem_wdata  write data = accumulator (valid while mem_req & mem_we)
//   mem_rdata  read data, sampled when mem_ack = 1
//   mem_ack    access complete
//   halt       high while halted
//   zero       accumulator equals zero
//   pc         program counter (debug)
//   accum      accumulator (debug)
//   instr_cnt  retired-instruction count, wraps at 2^CW
//   state_dbg  current sequencer state code (debug)
// ---------------------------------------------------------------------------
module cpu_seq_m #(
   parameter int DW = 8,
   parameter int AW = 5,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_,
   input  logic          run,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          halt,
   output logic          zero,
   output logic [AW-1:0] pc,
   output logic [DW-1:0] accum,
   output logic [CW-1:0] instr_cnt,
   output logic [2:0]    state_dbg
);

   // The opcode occupies the top three bits and the operand address the low
   // AW bits, so both fields must fit in one word.
   generate
      if (DW < AW + 3) begin : g_width_check
         $error("cpu_seq_m: DW must be at least AW+3");
      end
   endgenerate

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   typedef enum logic [2:0] {
      S_START  = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_READ   = 3'd3,
      S_WRITE  = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t        state, state_nx;
   logic [DW-1:0] ir, ir_nx;
   logic [DW-1:0] accum_nx;
   logic [AW-1:0] pc_nx;
   logic [CW-1:0] cnt_nx;
   logic          retire;

   logic [2:0]    opcode;
   logic [AW-1:0] ir_addr;

   assign opcode    = ir[DW-1 -: 3];
   assign ir_addr   = ir[AW-1:0];
   assign zero      = (accum == '0);
   assign state_dbg = state;

   // State and datapath registers. Reset returns the sequencer to S_START,
   // which drops mem_req immediately, so an access in flight is abandoned.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state     <= S_START;
         pc        <= '0;
         accum     <= '0;
         ir        <= '0;
         instr_cnt <= '0;
      end else begin
         state     <= state_nx;
         pc        <= pc_nx;
         accum     <= accum_nx;
         ir        <= ir_nx;
         instr_cnt <= cnt_nx;
      end
   end

   // Next-state, datapath and memory-port decode. The memory outputs depend
   // only on the state and on registered pc/ir/accum, so they cannot change
   // while a request waits for mem_ack.
   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      accum_nx  = accum;
      ir_nx     = ir;
      retire    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc;
      mem_wdata = accum;
      halt      = 1'b0;

      case (state)
         S_START: begin
            state_nx = S_FETCH;
         end

         S_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc;
            if (mem_ack) begin
               ir_nx    = mem_rdata;
               pc_nx    = pc + 1'b1;
               state_nx = S_DECODE;
            end
         end

         S_DECODE: begin
            case (opcode)
               OP_HLT: begin
                  retire   = 1'b1;
                  state_nx = S_HALT;
               end
               OP_SKZ: begin
                  retire   = 1'b1;
                  state_nx = S_FETCH;
                  if (accum == '0) begin
                     pc_nx = pc + 1'b1;
                  end
               end
               OP_JMP: begin
                  retire   = 1'b1;
                  pc_nx    = ir_addr;
                  state_nx = S_FETCH;
               end
               OP_STO: begin
                  state_nx = S_WRITE;
               end
               default: begin
                  // ADD, AND, XOR and LDA all need an operand read
                  state_nx = S_READ;
               end
            endcase
         end

         S_READ: begin
            mem_req  = 1'b1;
            mem_addr = ir_addr;
            if (mem_ack) begin
               case (opcode)
                  OP_ADD:  accum_nx = accum + mem_rdata;
                  OP_AND:  accum_nx = accum & mem_rdata;
                  OP_XOR:  accum_nx = accum ^ mem_rdata;
                  default: accum_nx = mem_rdata;
               endcase
               retire   = 1'b1;
               state_nx = S_FETCH;
            end
         end

         S_WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ir_addr;
            mem_wdata = accum;
            if (mem_ack) begin
               retire   = 1'b1;
               state_nx = S_FETCH;
            end
         end

         S_HALT: begin
            halt = 1'b1;
            // pc already points past the HLT, so execution resumes after it
            if (run) begin
               state_nx = S_FETCH;
            end
         end

         default: begin
            state_nx = S_START;
         end
      endcase

      cnt_nx = instr_cnt + {{(CW-1){1'b0}}, retire};
   end

endmodule
